// File: rtl/ac_pkg.sv
// Shared constants and types for the air-conditioning controller blocks.
package ac_pkg;

  localparam int unsigned TEMP_W = 5;

  localparam logic [TEMP_W-1:0] T_HEAT = 5'd18;
  localparam logic [TEMP_W-1:0] T_COOL = 5'd22;

  // Mid comfort band, so the AC block stays idle until real data arrives.
  localparam int unsigned RESET_TEMP_DEF = 20;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDrain
  } fe_state_e;

endpackage

// File: rtl/temp_avg.sv
// Moving average over the last 2**AVG_LOG2 accepted samples; output registered one
// cycle after the sample is loaded.
module temp_avg
  import ac_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = TEMP_W,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned RESET_TEMP = RESET_TEMP_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [SAMPLE_W-1:0] temp_o,
  output logic                valid_o
);

  localparam int unsigned Depth = 1 << AVG_LOG2;
  localparam int unsigned SumW  = SAMPLE_W + AVG_LOG2;

  logic [SAMPLE_W-1:0] hist_q [Depth];
  logic                filled_q;
  logic                upd_q;
  logic [SAMPLE_W-1:0] temp_q;
  logic                valid_q;
  logic [SumW-1:0]     sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      sum = sum + SumW'(hist_q[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        hist_q[i] <= '0;
      end
      filled_q <= 1'b0;
      upd_q    <= 1'b0;
      temp_q   <= SAMPLE_W'(RESET_TEMP);
      valid_q  <= 1'b0;
    end else begin
      upd_q   <= load_i;
      valid_q <= upd_q;
      if (load_i) begin
        filled_q  <= 1'b1;
        hist_q[0] <= sample_i;
        // An empty history is seeded with the first sample so the average starts there.
        for (int i = 1; i < int'(Depth); i++) begin
          hist_q[i] <= filled_q ? hist_q[i-1] : sample_i;
        end
      end
      if (upd_q) begin
        temp_q <= SAMPLE_W'(sum >> AVG_LOG2);
      end
    end
  end

  assign temp_o  = temp_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/temp_sensor_frontend.sv
// Framed serial receiver for the room sensor: deframes MSB-first samples, rejects
// malformed frames, averages accepted samples and flags a stalled sensor.
module temp_sensor_frontend
  import ac_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = TEMP_W,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned RESET_TEMP  = RESET_TEMP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sdata,
  input  logic                sframe,
  output logic [SAMPLE_W-1:0] temperature,
  output logic                temp_valid,
  output logic                sensor_fault,
  output logic                bad_frame
);

  localparam int unsigned CntW = $clog2(SAMPLE_W + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYC + 1);

  fe_state_e           state_q;
  logic [CntW-1:0]     cnt_q;
  logic [SAMPLE_W-1:0] shift_q;
  logic [ToW-1:0]      to_q;
  logic                bad_q;
  logic                fault_q;
  logic                full;
  logic                accept;

  assign full   = (cnt_q == CntW'(SAMPLE_W));
  assign accept = (state_q == StShift) && !sframe && full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      to_q    <= '0;
      bad_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      bad_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (sframe) begin
            shift_q <= {shift_q[SAMPLE_W-2:0], sdata};
            cnt_q   <= CntW'(1);
            state_q <= StShift;
          end
        end
        StShift: begin
          if (sframe) begin
            if (full) begin
              state_q <= StDrain;
            end else begin
              shift_q <= {shift_q[SAMPLE_W-2:0], sdata};
              cnt_q   <= cnt_q + CntW'(1);
            end
          end else begin
            bad_q   <= !full;
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        StDrain: begin
          if (!sframe) begin
            bad_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (accept) begin
        to_q <= '0;
      end else if (to_q != ToW'(TIMEOUT_CYC)) begin
        to_q <= to_q + ToW'(1);
      end
      // Looks at the pre-clear count, so the fault drops the cycle after an accept.
      fault_q <= (to_q == ToW'(TIMEOUT_CYC));
    end
  end

  temp_avg #(
    .SAMPLE_W  (SAMPLE_W),
    .AVG_LOG2  (AVG_LOG2),
    .RESET_TEMP(RESET_TEMP)
  ) u_avg (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (accept),
    .sample_i(shift_q),
    .temp_o  (temperature),
    .valid_o (temp_valid)
  );

  assign sensor_fault = fault_q;
  assign bad_frame    = bad_q;

endmodule

// File: tb/tb_temp_sensor_frontend.sv
// Directed bench for temp_sensor_frontend: table of frames plus hand-timed sequences.
module tb_temp_sensor_frontend;

  logic       clk;
  logic       rst;
  logic       sdata;
  logic       sframe;
  logic [4:0] temperature;
  logic       temp_valid;
  logic       sensor_fault;
  logic       bad_frame;

  int total  = 0;
  int passed = 0;
  int vcnt   = 0;
  int bcnt   = 0;

  typedef struct {
    logic [4:0] value;
    int         len;
    logic [4:0] exp_temp;
    int         exp_valid;
    int         exp_bad;
  } vec_t;

  vec_t vecs [12];

  temp_sensor_frontend dut (
    .clk         (clk),
    .rst         (rst),
    .sdata       (sdata),
    .sframe      (sframe),
    .temperature (temperature),
    .temp_valid  (temp_valid),
    .sensor_fault(sensor_fault),
    .bad_frame   (bad_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (temp_valid) vcnt++;
    if (bad_frame) bcnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_bits(input logic [4:0] v, input int len);
    for (int i = 0; i < len; i++) begin
      sframe = 1'b1;
      sdata  = (i < 5) ? v[4-i] : 1'b0;
      step();
    end
    sframe = 1'b0;
    sdata  = 1'b0;
  endtask

  // Good frame with exact latency checks: E0 no pulse, E1 pulse + value, then pulse gone.
  task automatic send_good(input logic [4:0] v, input logic [4:0] exp, input string name);
    frame_bits(v, 5);
    step();
    chk({name, "_e0_valid"}, int'(temp_valid), 0);
    step();
    chk({name, "_e1_temp"}, int'(temperature), int'(exp));
    chk({name, "_e1_valid"}, int'(temp_valid), 1);
    step();
    chk({name, "_e2_valid"}, int'(temp_valid), 0);
  endtask

  initial begin
    int v0;
    int b0;

    vecs[0]  = '{5'd24, 5, 5'd18, 1, 0};
    vecs[1]  = '{5'd24, 5, 5'd20, 1, 0};
    vecs[2]  = '{5'd24, 5, 5'd22, 1, 0};
    vecs[3]  = '{5'd24, 5, 5'd24, 1, 0};
    vecs[4]  = '{5'd17, 5, 5'd22, 1, 0};
    vecs[5]  = '{5'd17, 5, 5'd20, 1, 0};
    vecs[6]  = '{5'd17, 5, 5'd18, 1, 0};
    vecs[7]  = '{5'd18, 5, 5'd17, 1, 0};
    vecs[8]  = '{5'd31, 3, 5'd17, 0, 1};
    vecs[9]  = '{5'd0,  7, 5'd17, 0, 1};
    vecs[10] = '{5'd31, 1, 5'd17, 0, 1};
    vecs[11] = '{5'd0,  5, 5'd13, 1, 0};

    rst    = 1'b1;
    sdata  = 1'b0;
    sframe = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_temp", int'(temperature), 20);
    chk("reset_valid", int'(temp_valid), 0);
    chk("reset_fault", int'(sensor_fault), 0);
    chk("reset_bad", int'(bad_frame), 0);

    send_good(5'd16, 5'd16, "first16");

    for (int k = 0; k < 12; k++) begin
      v0 = vcnt;
      b0 = bcnt;
      frame_bits(vecs[k].value, vecs[k].len);
      repeat (4) step();
      chk($sformatf("vec%0d_temp", k), int'(temperature), int'(vecs[k].exp_temp));
      chk($sformatf("vec%0d_valid_pulses", k), vcnt - v0, vecs[k].exp_valid);
      chk($sformatf("vec%0d_bad_pulses", k), bcnt - b0, vecs[k].exp_bad);
      chk($sformatf("vec%0d_fault", k), int'(sensor_fault), 0);
    end

    // Short-frame pulse timing: bad_frame for exactly the cycle after sframe drops.
    frame_bits(5'd7, 2);
    step();
    chk("short_bad_hi", int'(bad_frame), 1);
    chk("short_no_valid", int'(temp_valid), 0);
    step();
    chk("short_bad_lo", int'(bad_frame), 0);

    // Timeout: fault rises only after the counter saturates, temperature held.
    repeat (50) step();
    chk("timeout_early", int'(sensor_fault), 0);
    repeat (20) step();
    chk("timeout_fault", int'(sensor_fault), 1);
    chk("timeout_temp_held", int'(temperature), 13);
    frame_bits(5'd9, 5);
    step();
    chk("fault_at_e0", int'(sensor_fault), 1);
    step();
    chk("fault_at_e1", int'(sensor_fault), 0);
    chk("fault_clear_temp", int'(temperature), 11);

    // Back-to-back frames separated by a single low cycle.
    step();
    v0 = vcnt;
    b0 = bcnt;
    frame_bits(5'd20, 5);
    step();
    frame_bits(5'd4, 5);
    step();
    step();
    chk("b2b_temp", int'(temperature), 8);
    chk("b2b_valid", int'(temp_valid), 1);
    step();
    chk("b2b_pulses", vcnt - v0, 2);
    chk("b2b_bad", bcnt - b0, 0);

    // Asynchronous reset in the middle of a frame.
    sframe = 1'b1;
    sdata  = 1'b1;
    step();
    step();
    sdata = 1'b0;
    step();
    #2;
    rst    = 1'b1;
    sframe = 1'b0;
    #1;
    chk("async_rst_temp", int'(temperature), 20);
    chk("async_rst_valid", int'(temp_valid), 0);
    chk("async_rst_fault", int'(sensor_fault), 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_temp", int'(temperature), 20);
    chk("post_rst_bad", int'(bad_frame), 0);
    send_good(5'd25, 5'd25, "seed25");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
